// File: rtl/inst_cache_dm_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
package inst_cache_dm_pkg;

    localparam int ICACHE_INDEX_W = 6;
    localparam int ICACHE_ADDR_W  = 32;
    localparam int ICACHE_DATA_W  = 32;
    localparam logic [ICACHE_DATA_W-1:0] ICACHE_ZERO_WORD = '0;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_REQ  = 1'b1
    } icache_state_t;

endpackage

// File: rtl/inst_cache_dm_tag_data_array.sv
// Valid/tag/data storage for the instruction cache: async read, sync write,
// single-cycle global invalidate.
module inst_cache_dm_tag_data_array
    import inst_cache_dm_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_ADDR_W - ICACHE_INDEX_W - 2,
    parameter int DATA_W  = ICACHE_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [DATA_W-1:0]  i_wr_data,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [DATA_W-1:0]  o_rd_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Invalidate wins over a fill landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped one-word-per-line instruction cache with a req/ack refill port.
// Define ICACHE_PERF_CNT_EN to add hit_cnt_o / miss_cnt_o performance counters.
//
//   state       | meaning
//   ICACHE_IDLE | serving hits; a miss latches the line address and requests it
//   ICACHE_REQ  | memory request outstanding until mem_ack_i
module inst_cache_dm
    import inst_cache_dm_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int ADDR_W  = ICACHE_ADDR_W,
    parameter int DATA_W  = ICACHE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              stall_req_o,
    input  logic              flush_i,
    output logic              mem_ce_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic              mem_ack_i
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    icache_state_t     r_state;
    logic              r_mem_ce;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_discard;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_hit;
    logic               w_miss_start;
    logic               w_fill;
    logic               w_unused_byte_off;

    assign w_index           = cpu_addr_i[INDEX_W+1:2];
    assign w_tag             = cpu_addr_i[ADDR_W-1:INDEX_W+2];
    assign w_unused_byte_off = ^cpu_addr_i[1:0];

    assign w_hit = cpu_ce_i && w_rd_valid && (w_rd_tag == w_tag) && (r_state == ICACHE_IDLE);
    assign w_miss_start = (r_state == ICACHE_IDLE) && cpu_ce_i && !w_hit;

    // A flush seen during the request, or on the ack cycle itself, keeps stale data out.
    assign w_fill = (r_state == ICACHE_REQ) && mem_ack_i && !r_discard && !flush_i;

    assign cpu_inst_o  = w_hit ? w_rd_data : ICACHE_ZERO_WORD;
    assign stall_req_o = cpu_ce_i && !w_hit;
    assign mem_ce_o    = r_mem_ce;
    assign mem_addr_o  = r_mem_addr;

    inst_cache_dm_tag_data_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (flush_i),
        .i_we       (w_fill),
        .i_wr_index (r_mem_addr[INDEX_W+1:2]),
        .i_wr_tag   (r_mem_addr[ADDR_W-1:INDEX_W+2]),
        .i_wr_data  (mem_data_i),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ICACHE_IDLE;
            r_mem_ce   <= 1'b0;
            r_mem_addr <= '0;
            r_discard  <= 1'b0;
        end else begin
            case (r_state)
                ICACHE_IDLE: begin
                    if (w_miss_start) begin
                        r_state    <= ICACHE_REQ;
                        r_mem_ce   <= 1'b1;
                        r_mem_addr <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
                        r_discard  <= 1'b0;
                    end
                end
                ICACHE_REQ: begin
                    if (mem_ack_i) begin
                        r_state    <= ICACHE_IDLE;
                        r_mem_ce   <= 1'b0;
                        r_mem_addr <= '0;
                        r_discard  <= 1'b0;
                    end else if (flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ICACHE_IDLE;
                    r_mem_ce   <= 1'b0;
                    r_mem_addr <= '0;
                    r_discard  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed self-checking bench for inst_cache_dm (counters checked when
// ICACHE_PERF_CNT_EN is defined).
module tb_inst_cache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_inst_o;
    logic        stall_req_o;
    logic        flush_i;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_cache_dm dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_inst_o  (cpu_inst_o),
        .stall_req_o (stall_req_o),
        .flush_i     (flush_i),
        .mem_ce_o    (mem_ce_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o),
`endif
        .mem_ack_i   (mem_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE at posedge+1; returns at posedge+1 just after the fill edge.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int lat);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = a;
        #1;
        chk("miss_idle_stall", {31'd0, stall_req_o}, 32'd1);
        chk("miss_idle_no_req", {31'd0, mem_ce_o}, 32'd0);
        tick();
        for (int i = 0; i < lat - 1; i++) begin
            chk("req_ce", {31'd0, mem_ce_o}, 32'd1);
            chk("req_addr", mem_addr_o, {a[31:2], 2'b00});
            chk("req_stall", {31'd0, stall_req_o}, 32'd1);
            tick();
        end
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        #1;
        chk("ack_ce", {31'd0, mem_ce_o}, 32'd1);
        chk("ack_addr", mem_addr_o, {a[31:2], 2'b00});
        chk("ack_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = 32'd0;
    endtask

    initial begin
        rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = 32'd0; flush_i = 1'b0;
        mem_data_i = 32'd0; mem_ack_i = 1'b0;
        tick();
        tick();
        chk("rst_mem_ce", {31'd0, mem_ce_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        chk("rst_inst", cpu_inst_o, 32'd0);
        rst = 1'b0;
        tick();

        // cold miss, 3-cycle memory
        do_miss(32'h0000_0000, 32'h3401_1100, 3);
        #1;
        chk("cold_hit_inst", cpu_inst_o, 32'h3401_1100);
        chk("cold_hit_stall", {31'd0, stall_req_o}, 32'd0);
        chk("cold_hit_no_req", {31'd0, mem_ce_o}, 32'd0);
        tick();
        chk("refetch_inst", cpu_inst_o, 32'h3401_1100);
        chk("refetch_no_req", {31'd0, mem_ce_o}, 32'd0);
        tick();

        // conflict on index 0
        do_miss(32'h0000_0100, 32'hDEAD_BEEF, 2);
        #1;
        chk("conflict_inst", cpu_inst_o, 32'hDEAD_BEEF);
        chk("conflict_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        do_miss(32'h0000_0000, 32'h3401_1100, 1);
        #1;
        chk("reload_inst", cpu_inst_o, 32'h3401_1100);
        tick();
        cpu_addr_i = 32'h0000_0003;
        #1;
        chk("byte_off_inst", cpu_inst_o, 32'h3401_1100);
        chk("byte_off_stall", {31'd0, stall_req_o}, 32'd0);
        tick();

        // flush while the request is outstanding
        cpu_addr_i = 32'h0000_0004;
        #1;
        chk("fl_miss_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        flush_i = 1'b1;
        #1;
        chk("fl_req_ce", {31'd0, mem_ce_o}, 32'd1);
        chk("fl_req_addr", mem_addr_o, 32'h0000_0004);
        tick();
        flush_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hAAAA_5555;
        #1;
        chk("fl_ack_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        mem_ack_i = 1'b0; mem_data_i = 32'd0;
        #1;
        chk("fl_discard_stall", {31'd0, stall_req_o}, 32'd1);
        chk("fl_discard_inst", cpu_inst_o, 32'd0);
        chk("fl_idle_no_req", {31'd0, mem_ce_o}, 32'd0);
        tick();
        chk("fl_rereq_ce", {31'd0, mem_ce_o}, 32'd1);
        chk("fl_rereq_addr", mem_addr_o, 32'h0000_0004);
        chk("fl_rereq_stall", {31'd0, stall_req_o}, 32'd1);
        mem_ack_i = 1'b1; mem_data_i = 32'h1111_2222;
        tick();
        mem_ack_i = 1'b0; mem_data_i = 32'd0;
        #1;
        chk("fl_refill_inst", cpu_inst_o, 32'h1111_2222);
        tick();
        cpu_addr_i = 32'h0000_0000;
        #1;
        chk("fl_line0_gone", {31'd0, stall_req_o}, 32'd1);
        tick();

        // reset while in REQ, then a stray ack
        chk("rm_req_ce", {31'd0, mem_ce_o}, 32'd1);
        rst = 1'b1; cpu_ce_i = 1'b0;
        tick();
        chk("rm_ce_dropped", {31'd0, mem_ce_o}, 32'd0);
        chk("rm_addr_cleared", mem_addr_o, 32'd0);
        chk("rm_stall", {31'd0, stall_req_o}, 32'd0);
        rst = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'h5A5A_5A5A;
        tick();
        mem_ack_i = 1'b0; mem_data_i = 32'd0;
        chk("stray_ack_no_req", {31'd0, mem_ce_o}, 32'd0);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0004;
        #1;
        chk("rm_line1_invalid", {31'd0, stall_req_o}, 32'd1);
        chk("rm_line1_inst", cpu_inst_o, 32'd0);
        do_miss(32'h0000_0000, 32'h3401_1100, 3);
        #1;
        chk("rm_refill_inst", cpu_inst_o, 32'h3401_1100);
        tick();

        // fetch disabled
        cpu_ce_i = 1'b0; cpu_addr_i = 32'h0000_0100;
        #1;
        chk("ce_low_inst", cpu_inst_o, 32'd0);
        chk("ce_low_stall", {31'd0, stall_req_o}, 32'd0);
        tick();
        chk("ce_low_no_req", {31'd0, mem_ce_o}, 32'd0);

        // flush coincident with ack
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0008;
        #1;
        chk("fa_miss_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        flush_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h7777_7777;
        tick();
        flush_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = 32'd0;
        #1;
        chk("fa_not_installed", {31'd0, stall_req_o}, 32'd1);
        chk("fa_inst", cpu_inst_o, 32'd0);
        tick();
        mem_ack_i = 1'b1; mem_data_i = 32'h8888_8888;
        tick();
        mem_ack_i = 1'b0; mem_data_i = 32'd0;
        #1;
        chk("fa_refill_inst", cpu_inst_o, 32'h8888_8888);
        tick();
        cpu_addr_i = 32'h0000_0000;
        #1;
        chk("fa_line0_gone", {31'd0, stall_req_o}, 32'd1);
        cpu_ce_i = 1'b0;
        tick();

`ifdef ICACHE_PERF_CNT_EN
        // since the mid-miss reset: hits at 0x0 and 0x8, misses 0x0, 0x8, 0x8
        chk("hit_cnt", hit_cnt_o, 32'd2);
        chk("miss_cnt", miss_cnt_o, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
